iq_modulator: RTL and testbench

Transmit-side counterpart to the IQ demodulator. Accepts baseband I/Q sample pairs at a low, irregular rate and up-converts them onto an internal phase-continuous carrier: signal_out = I·cos(φ) − Q·sin(φ). Output is one 14-bit sample per CLK, formatted for the same DAC/ADC loopback path the demodulator consumes. The block owns its own phase accumulator, a zero-order-hold input stage with underrun detection, and a 3-stage arithmetic pipeline.

---
 rtl/iq_pkg.sv | 23 ++
 rtl/sin_cos_lut.sv | 43 ++++
 rtl/iq_modulator.sv | 196 +++++++++++++++++++
 tb/tb_iq_modulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_pkg
// Description : Shared constants and types for the IQ modulator/demodulator pair.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_pkg;

    localparam int DATA_W           = 14;
    localparam int PHASE_W          = 32;
    localparam int LUT_AW           = 10;
    localparam int CARRIER_AMP      = 8191;
    localparam int ROUND_SHIFT      = 13;
    localparam int HOLD_MAX_DEFAULT = 65535;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        UNDERRUN = 2'd2
    } iq_state_t;

endpackage : iq_pkg
`default_nettype wire

// File: rtl/sin_cos_lut.sv
`default_nettype none
// ============================================================================
// Module      : sin_cos_lut
// Description : Full-period registered sine/cosine table, amplitude 8191.
// Revision    : 1.0 - initial release
// ============================================================================
module sin_cos_lut
    import iq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LUT_AW-1:0]        i_addr,
    output logic signed [DATA_W-1:0] o_sin,
    output logic signed [DATA_W-1:0] o_cos
);

    localparam int  c_depth  = 1 << LUT_AW;
    localparam real c_two_pi = 6.283185307179586;

    logic signed [DATA_W-1:0] w_tab [c_depth];
    logic [LUT_AW-1:0]        w_cos_addr;

    // Table contents are elaboration-time constants; real math folds away.
    for (genvar g = 0; g < c_depth; g++) begin : g_tab
        assign w_tab[g] = DATA_W'(int'(real'(CARRIER_AMP) *
                          $sin(c_two_pi * real'(g) / real'(c_depth))));
    end

    // Cosine is the sine a quarter period ahead.
    assign w_cos_addr = i_addr + LUT_AW'(c_depth / 4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sin <= '0;
            o_cos <= '0;
        end else begin
            o_sin <= w_tab[i_addr];
            o_cos <= w_tab[w_cos_addr];
        end
    end

endmodule : sin_cos_lut
`default_nettype wire

// File: rtl/iq_modulator.sv
`default_nettype none
// ============================================================================
// Module      : iq_modulator
// Description : Up-converts held baseband I/Q onto an NCO carrier: I*cos - Q*sin.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_modulator
    import iq_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [PHASE_W-1:0]        phaseInc,
    input  logic                      phaseLoad,
    input  logic                      phaseClear,
    input  logic signed [DATA_W-1:0]  I_in,
    input  logic signed [DATA_W-1:0]  Q_in,
    input  logic                      inValid,
    output logic                      inReady,
    output logic signed [DATA_W-1:0]  signal_out,
    output logic                      outValid,
    output logic                      satFlag,
    output logic                      underrun
);

    localparam int c_cnt_w  = $clog2(HOLD_MAX + 1);
    localparam int c_prod_w = 2 * DATA_W;
    localparam int c_diff_w = 2 * DATA_W + 1;

    localparam logic [c_cnt_w-1:0]          c_cnt_last = c_cnt_w'(HOLD_MAX - 1);
    localparam logic [c_cnt_w-1:0]          c_cnt_sat  = c_cnt_w'(HOLD_MAX);
    localparam logic signed [c_diff_w-1:0]  c_round    = c_diff_w'(1 << (ROUND_SHIFT - 1));
    localparam logic signed [c_diff_w-1:0]  c_pos_lim  = c_diff_w'(CARRIER_AMP);
    localparam logic signed [c_diff_w-1:0]  c_neg_lim  = c_diff_w'(-CARRIER_AMP - 1);
    localparam logic signed [DATA_W-1:0]    c_out_max  = DATA_W'(CARRIER_AMP);
    localparam logic signed [DATA_W-1:0]    c_out_min  = DATA_W'(-CARRIER_AMP - 1);

    logic [PHASE_W-1:0]         r_phase;
    logic [PHASE_W-1:0]         r_inc;
    logic [LUT_AW-1:0]          w_lut_addr;
    logic signed [DATA_W-1:0]   w_sin;
    logic signed [DATA_W-1:0]   w_cos;

    logic                       r_ready;
    logic [2:0]                 r_vpipe;
    logic                       w_accept;

    iq_state_t                  r_state;
    iq_state_t                  w_state_nxt;
    logic signed [DATA_W-1:0]   r_hold_i;
    logic signed [DATA_W-1:0]   r_hold_q;
    logic signed [DATA_W-1:0]   w_hold_i_nxt;
    logic signed [DATA_W-1:0]   w_hold_q_nxt;
    logic [c_cnt_w-1:0]         r_idle_cnt;
    logic [c_cnt_w-1:0]         w_idle_nxt;

    logic signed [c_prod_w-1:0] r_prod_i;
    logic signed [c_prod_w-1:0] r_prod_q;
    logic signed [c_diff_w-1:0] w_diff;
    logic signed [c_diff_w-1:0] w_sum;
    logic signed [c_diff_w-1:0] w_scaled;

    // ------------------------------------------------------------------
    // Phase accumulator: a new increment only affects the next add, so
    // frequency changes stay phase-continuous.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            r_inc   <= '0;
        end else begin
            if (phaseClear) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + r_inc;
            end
            if (phaseLoad) begin
                r_inc <= phaseInc;
            end
        end
    end

    assign w_lut_addr = r_phase[PHASE_W-1 -: LUT_AW];

    sin_cos_lut u_lut (
        .clk    (CLK),
        .rst    (reset),
        .i_addr (w_lut_addr),
        .o_sin  (w_sin),
        .o_cos  (w_cos)
    );

    // Ready rises on the first edge after reset; outValid after the third.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_vpipe <= '0;
        end else begin
            r_ready <= 1'b1;
            r_vpipe <= {r_vpipe[1:0], 1'b1};
        end
    end

    assign inReady  = r_ready;
    assign outValid = r_vpipe[2];
    assign w_accept = inValid & r_ready;

    // ------------------------------------------------------------------
    // Zero-order-hold input stage with starvation detection
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_i   <= '0;
            r_hold_q   <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_i   <= w_hold_i_nxt;
            r_hold_q   <= w_hold_q_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_i_nxt = r_hold_i;
        w_hold_q_nxt = r_hold_q;
        w_idle_nxt   = r_idle_cnt;
        if (w_accept) begin
            w_state_nxt  = RUN;
            w_hold_i_nxt = I_in;
            w_hold_q_nxt = Q_in;
            w_idle_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                RUN: begin
                    if (r_idle_cnt == c_cnt_last) begin
                        w_state_nxt  = UNDERRUN;
                        w_hold_i_nxt = '0;
                        w_hold_q_nxt = '0;
                        w_idle_nxt   = c_cnt_sat;
                    end else begin
                        w_idle_nxt = r_idle_cnt + c_cnt_w'(1);
                    end
                end
                UNDERRUN: begin
                    w_idle_nxt = c_cnt_sat;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign underrun = (r_state == UNDERRUN);

    // ------------------------------------------------------------------
    // Arithmetic pipeline: products, then round/saturate
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_prod_i <= '0;
            r_prod_q <= '0;
        end else begin
            r_prod_i <= c_prod_w'(r_hold_i) * c_prod_w'(w_cos);
            r_prod_q <= c_prod_w'(r_hold_q) * c_prod_w'(w_sin);
        end
    end

    assign w_diff   = c_diff_w'(r_prod_i) - c_diff_w'(r_prod_q);
    assign w_sum    = w_diff + c_round;
    assign w_scaled = w_sum >>> ROUND_SHIFT;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            signal_out <= '0;
            satFlag    <= 1'b0;
        end else if (w_scaled > c_pos_lim) begin
            signal_out <= c_out_max;
            satFlag    <= 1'b1;
        end else if (w_scaled < c_neg_lim) begin
            signal_out <= c_out_min;
            satFlag    <= 1'b1;
        end else begin
            signal_out <= w_scaled[DATA_W-1:0];
            satFlag    <= 1'b0;
        end
    end

endmodule : iq_modulator
`default_nettype wire

// File: tb/tb_iq_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_modulator
// Description : Self-checking bench: directed vectors plus random traffic vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_modulator;
    import iq_pkg::*;

    localparam int  c_hold   = 16;
    localparam real c_two_pi = 6.283185307179586;

    logic                     CLK = 1'b0;
    logic                     reset = 1'b0;
    logic [31:0]              phaseInc = '0;
    logic                     phaseLoad = 1'b0;
    logic                     phaseClear = 1'b0;
    logic signed [13:0]       I_in = '0;
    logic signed [13:0]       Q_in = '0;
    logic                     inValid = 1'b0;
    logic                     inReady;
    logic signed [13:0]       signal_out;
    logic                     outValid;
    logic                     satFlag;
    logic                     underrun;

    always #40 CLK = ~CLK;

    iq_modulator #(.HOLD_MAX(c_hold)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .phaseInc   (phaseInc),
        .phaseLoad  (phaseLoad),
        .phaseClear (phaseClear),
        .I_in       (I_in),
        .Q_in       (Q_in),
        .inValid    (inValid),
        .inReady    (inReady),
        .signal_out (signal_out),
        .outValid   (outValid),
        .satFlag    (satFlag),
        .underrun   (underrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: held sample + carrier phase snapshots, two-edge delay
    typedef struct { int hi; int hq; int s; int c; } snap_t;
    logic [31:0] m_phase, m_inc;
    int          m_hi, m_hq, m_idle, m_edges;
    bit          m_started, m_und;
    snap_t       m_hist[2];
    int          e_out;
    bit          e_sat;

    typedef struct {
        logic [31:0] inc;
        int          i;
        int          q;
        int          off;
        int          exp_out;
        bit          exp_sat;
    } vec_t;
    vec_t vecs[12];

    function automatic int lut(int a);
        return int'(8191.0 * $sin(c_two_pi * real'(a % 1024) / 1024.0));
    endfunction

    task automatic mod_out(input snap_t s, output int o, output bit sat);
        longint d, r;
        d = longint'(s.hi) * s.c - longint'(s.hq) * s.s;
        r = longint'($floor((real'(d) + 4096.0) / 8192.0));
        o = int'(r);
        sat = 1'b0;
        if (r > 8191) begin
            o = 8191;
            sat = 1'b1;
        end else if (r < -8192) begin
            o = -8192;
            sat = 1'b1;
        end
    endtask

    task automatic model_reset();
        snap_t z;
        z = '{0, 0, 0, 0};
        m_phase = '0; m_inc = '0;
        m_hi = 0; m_hq = 0; m_idle = 0; m_edges = 0;
        m_started = 1'b0; m_und = 1'b0;
        m_hist[0] = z; m_hist[1] = z;
        e_out = 0; e_sat = 1'b0;
    endtask

    task automatic model_edge();
        snap_t cur;
        bit    acc;
        int    a;
        if (reset) begin
            model_reset();
            return;
        end
        mod_out(m_hist[1], e_out, e_sat);
        acc = inValid && (m_edges >= 1);
        a = int'(m_phase >> 22);
        cur.s = lut(a);
        cur.c = lut(a + 256);
        if (acc) begin
            m_hi = int'(I_in); m_hq = int'(Q_in);
            m_idle = 0; m_started = 1'b1; m_und = 1'b0;
        end else if (m_started && !m_und) begin
            m_idle++;
            if (m_idle >= c_hold) begin
                m_und = 1'b1; m_hi = 0; m_hq = 0;
            end
        end
        cur.hi = m_hi;
        cur.hq = m_hq;
        m_hist[1] = m_hist[0];
        m_hist[0] = cur;
        m_phase = phaseClear ? 32'd0 : m_phase + m_inc;
        if (phaseLoad) m_inc = phaseInc;
        if (m_edges < 1000) m_edges++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("signal_out", int'(signal_out), e_out);
        check("satFlag", int'(satFlag), int'(e_sat));
        check("outValid", int'(outValid), int'(m_edges >= 3));
        check("underrun", int'(underrun), int'(m_und));
        check("inReady", int'(inReady), int'(m_edges >= 1));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int n;

        vecs[0]  = '{32'h4000_0000,  4096,     0, 3,  4096, 1'b0};
        vecs[1]  = '{32'h4000_0000,  4096,     0, 4,     0, 1'b0};
        vecs[2]  = '{32'h4000_0000,  4096,     0, 5, -4095, 1'b0};
        vecs[3]  = '{32'h4000_0000,  4096,     0, 6,     0, 1'b0};
        vecs[4]  = '{32'h4000_0000,     0,  4096, 3,     0, 1'b0};
        vecs[5]  = '{32'h4000_0000,     0,  4096, 4, -4095, 1'b0};
        vecs[6]  = '{32'h4000_0000,     0,  4096, 5,     0, 1'b0};
        vecs[7]  = '{32'h4000_0000,     0,  4096, 6,  4096, 1'b0};
        vecs[8]  = '{32'h2000_0000,  8191, -8192, 3,  8190, 1'b0};
        vecs[9]  = '{32'h2000_0000,  8191, -8192, 4,  8191, 1'b1};
        vecs[10] = '{32'h2000_0000, -8192,  8191, 3, -8191, 1'b0};
        vecs[11] = '{32'h2000_0000, -8192,  8191, 4, -8192, 1'b1};

        // Reset state
        #5 reset = 1'b1;
        model_reset();
        #1 compare_all();
        step();
        step();
        reset = 1'b0;
        repeat (4) step();

        // Directed vectors
        for (int k = 0; k < 12; k++) begin
            I_in = 14'(vecs[k].i);
            Q_in = 14'(vecs[k].q);
            inValid = 1'b1;
            phaseInc = vecs[k].inc;
            phaseLoad = 1'b1;
            phaseClear = 1'b1;
            step();
            phaseLoad = 1'b0;
            phaseClear = 1'b0;
            repeat (vecs[k].off) step();
            check("vec_out", int'(signal_out), vecs[k].exp_out);
            check("vec_sat", int'(satFlag), int'(vecs[k].exp_sat));
        end

        // Underrun timing
        I_in = 14'sd3000; Q_in = '0; inValid = 1'b1;
        step();
        inValid = 1'b0;
        n = 0;
        while (!underrun && n < 40) begin
            step();
            n++;
        end
        check("underrun_delay", n, c_hold);
        step();
        step();
        check("underrun_zero_out", int'(signal_out), 0);
        check("underrun_held", int'(underrun), 1);
        inValid = 1'b1;
        step();
        check("underrun_clear", int'(underrun), 0);

        // Phase-continuous increment change
        I_in = 14'sd4096; Q_in = '0; inValid = 1'b1;
        phaseInc = 32'h4000_0000; phaseLoad = 1'b1; phaseClear = 1'b1;
        step();
        phaseLoad = 1'b0; phaseClear = 1'b0;
        step();
        phaseInc = 32'h2000_0000; phaseLoad = 1'b1;
        step();
        phaseLoad = 1'b0;
        repeat (3) step();
        check("switch_before", int'(signal_out), -4095);
        step();
        check("switch_after", int'(signal_out), -2896);

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            inValid    = ($urandom_range(0, 9) == 0);
            I_in       = 14'($urandom);
            Q_in       = 14'($urandom);
            phaseLoad  = ($urandom_range(0, 49) == 0);
            phaseInc   = $urandom;
            phaseClear = ($urandom_range(0, 99) == 0);
            step();
        end

        // Mid-stream reset
        inValid = 1'b1; I_in = 14'sd5000; Q_in = -14'sd3000;
        phaseLoad = 1'b0; phaseClear = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        step();
        reset = 1'b0;
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 10) begin
            step();
            n++;
        end
        check("valid_after_reset", n, 3);
        repeat (25) step();
        check("idle_after_reset", int'(underrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_iq_modulator
`default_nettype wire
